// File: rtl/temporal_decoder_pkg.sv
// Shared definitions for temporal (spike-time) coding blocks: decoder FSM
// states and the result-width helper.
package temporal_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_DONE  = 2'd2
   } dec_state_t;

   // Result width: must hold every spike time plus the "no spike" code GAMMA_CYCLE_WIDTH.
   function automatic int value_width(input int gamma_cycle_width);
      return $clog2(gamma_cycle_width) + 1;
   endfunction

endpackage

// File: rtl/temporal_decoder_gamma_counter.sv
// Free-running gamma-cycle counter with registered start/end flags; shared
// by temporal encoders and decoders.
module gamma_counter #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   localparam int GW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1
) (
   input  logic          aclk,
   input  logic          grst,
   output logic [GW-1:0] g,
   output logic          gamma_start,
   output logic          gamma_end
);

   localparam logic [GW-1:0] G_LAST = GW'(GAMMA_CYCLE_WIDTH - 1);

   logic [GW-1:0] g_r;
   logic [GW-1:0] g_nxt_s;
   logic          start_r;
   logic          end_r;

   // Next count value, wrapping after the last cycle of the gamma period.
   always_comb begin
      g_nxt_s = '0;
      if (g_r == G_LAST) begin
         g_nxt_s = '0;
      end else begin
         g_nxt_s = g_r + GW'(1);
      end
   end

   // Count register; flags are decoded from the next count so they stay registered.
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         g_r     <= '0;
         start_r <= 1'b1;
         end_r   <= 1'b0;
      end else begin
         g_r     <= g_nxt_s;
         start_r <= (g_nxt_s == '0);
         end_r   <= (g_nxt_s == G_LAST);
      end
   end

   assign g           = g_r;
   assign gamma_start = start_r;
   assign gamma_end   = end_r;

endmodule

// File: rtl/temporal_decoder.sv
// Decodes a pulse-width-encoded spike into its arrival time within a gamma
// cycle, flagging pulse-width violations, with a held valid/ready result.
module temporal_decoder
   import temporal_decoder_pkg::*;
#(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8
) (
   input  logic                                      aclk,
   input  logic                                      grst,
   input  logic                                      spike_in,
   input  logic                                      out_ready,
   output logic                                      out_valid,
   output logic [value_width(GAMMA_CYCLE_WIDTH)-1:0] out_value,
   output logic                                      out_err,
   output logic                                      gamma_start,
   output logic                                      overrun
);

   localparam int VW = value_width(GAMMA_CYCLE_WIDTH);
   localparam int GW = VW - 1;
   localparam int WW = $clog2(PULSE_WIDTH + 2);
   localparam logic [WW-1:0] W_NOMINAL = WW'(PULSE_WIDTH);
   localparam logic [WW-1:0] W_SAT     = WW'(PULSE_WIDTH + 1);
   localparam logic [VW-1:0] V_NONE    = VW'(GAMMA_CYCLE_WIDTH);

   logic [GW-1:0] g_s;
   logic          gamma_start_s;
   logic          gamma_end_s;

   logic          prev_r;
   logic          edge_s;
   dec_state_t    state_r;
   dec_state_t    state_nxt_s;
   logic [GW-1:0] t_r;
   logic [GW-1:0] t_nxt_s;
   logic [WW-1:0] w_r;
   logic [WW-1:0] w_nxt_s;
   logic          err_r;
   logic          err_nxt_s;

   logic [VW-1:0] res_value_s;
   logic          res_err_s;

   logic          out_valid_r;
   logic [VW-1:0] out_value_r;
   logic          out_err_r;
   logic          overrun_r;

   gamma_counter #(
      .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)
   ) u_gamma_counter (
      .aclk        (aclk),
      .grst        (grst),
      .g           (g_s),
      .gamma_start (gamma_start_s),
      .gamma_end   (gamma_end_s)
   );

   // A level already high at gamma start counts as a fresh edge.
   assign edge_s = spike_in & ~(prev_r & ~gamma_start_s);

   // FSM next state and capture datapath for the current sample.
   always_comb begin
      state_nxt_s = state_r;
      t_nxt_s     = t_r;
      w_nxt_s     = w_r;
      err_nxt_s   = err_r;
      case (state_r)
         ST_IDLE: begin
            if (edge_s) begin
               state_nxt_s = ST_PULSE;
               t_nxt_s     = g_s;
               w_nxt_s     = WW'(1);
               err_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PULSE: begin
            if (spike_in) begin
               state_nxt_s = ST_PULSE;
               if (w_r != W_SAT) begin
                  w_nxt_s = w_r + WW'(1);
               end else begin
                  w_nxt_s = w_r;
               end
            end else begin
               state_nxt_s = ST_DONE;
               err_nxt_s   = (w_r != W_NOMINAL);
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_DONE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            t_nxt_s     = '0;
            w_nxt_s     = '0;
            err_nxt_s   = 1'b0;
         end
      endcase
   end

   // Result as seen after this cycle's sample; only loaded at the gamma end.
   always_comb begin
      res_value_s = V_NONE;
      res_err_s   = 1'b0;
      if (state_nxt_s == ST_IDLE) begin
         res_value_s = V_NONE;
         res_err_s   = 1'b0;
      end else begin
         res_value_s = {1'b0, t_nxt_s};
         res_err_s   = (state_nxt_s == ST_PULSE) | err_nxt_s;
      end
   end

   // Capture state; everything returns to IDLE for the next gamma cycle.
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         prev_r  <= 1'b0;
         state_r <= ST_IDLE;
         t_r     <= '0;
         w_r     <= '0;
         err_r   <= 1'b0;
      end else begin
         prev_r <= spike_in;
         if (gamma_end_s) begin
            state_r <= ST_IDLE;
            t_r     <= '0;
            w_r     <= '0;
            err_r   <= 1'b0;
         end else begin
            state_r <= state_nxt_s;
            t_r     <= t_nxt_s;
            w_r     <= w_nxt_s;
            err_r   <= err_nxt_s;
         end
      end
   end

   // Held result register; overrun flags a load over an unaccepted result.
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         out_valid_r <= 1'b0;
         out_value_r <= '0;
         out_err_r   <= 1'b0;
         overrun_r   <= 1'b0;
      end else if (gamma_end_s) begin
         out_valid_r <= 1'b1;
         out_value_r <= res_value_s;
         out_err_r   <= res_err_s;
         overrun_r   <= out_valid_r & ~out_ready;
      end else begin
         overrun_r <= 1'b0;
         if (out_valid_r & out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign out_valid   = out_valid_r;
   assign out_value   = out_value_r;
   assign out_err     = out_err_r;
   assign overrun     = overrun_r;
   assign gamma_start = gamma_start_s;

endmodule

// File: doc/temporal_decoder.md
TEMPORAL_DECODER -- requirements
Module: temporal_decoder

Interface
REQ-001 SHALL have parameter GAMMA_CYCLE_WIDTH, default 16: cycles per gamma cycle; legal range 2 or more.
REQ-002 SHALL have parameter PULSE_WIDTH, default 8: legal spike high-time in cycles; legal range 1 to GAMMA_CYCLE_WIDTH-1.
REQ-003 SHALL have port aclk  input  1  clock.
REQ-004 SHALL have port grst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port spike_in  input  1  pulse-width-encoded spike from a min/max stage.
REQ-006 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-007 SHALL have port out_valid  output  1  result held.
REQ-008 SHALL have port out_value  output  VW  spike time; VW = $clog2(GAMMA_CYCLE_WIDTH)+1.
REQ-009 SHALL have port out_err  output  1  pulse-width violation attached to out_value.
REQ-010 SHALL have port gamma_start  output  1  high when the gamma counter equals 0.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when an unaccepted result is overwritten.

Function
REQ-012 SHALL keep a gamma counter g that counts 0 to GAMMA_CYCLE_WIDTH-1 every cycle and wraps to 0.
REQ-013 SHALL detect a spike edge when spike_in=1 and the previous-cycle sample was 0; the previous sample SHALL be forced to 0 at g==0, so a level already high at a gamma start counts as an edge at g=0.
REQ-014 SHALL use an FSM with states IDLE, PULSE and DONE, and SHALL enter IDLE when g==0.
REQ-015 In IDLE, an edge SHALL capture t=g, set the width count to 1 and go to PULSE.
REQ-016 In PULSE, spike_in=1 SHALL increment the width count, saturating at PULSE_WIDTH+1.
REQ-017 In PULSE, spike_in=0 SHALL go to DONE and set err when the width count is not PULSE_WIDTH.
REQ-018 In DONE, all further edges in the same gamma cycle SHALL be ignored.
REQ-019 In the cycle with g==GAMMA_CYCLE_WIDTH-1, that cycle's sample included, the result SHALL be formed as follows.
REQ-020 If no edge was seen, the result SHALL be value=GAMMA_CYCLE_WIDTH (no spike / infinity) with err=0.
REQ-021 If an edge was seen, the result SHALL be value=t, and err SHALL be set when the pulse is still high at the gamma end or its width was not PULSE_WIDTH.
REQ-022 The result SHALL appear on out_value/out_err with out_valid=1 in the next cycle, which is the cycle with g==0, a latency of 1 cycle.
REQ-023 out_value/out_err SHALL hold while out_valid=1 and out_ready=0.
REQ-024 out_valid SHALL clear one cycle after out_valid=1 and out_ready=1, unless a new result loads in that same cycle.
REQ-025 If a new result loads while out_valid=1 and out_ready=0, the register SHALL be overwritten and overrun SHALL pulse.
REQ-026 A new result loading in the same cycle as out_valid=1 and out_ready=1 SHALL produce no overrun.
REQ-027 For PULSE_WIDTH-saturated pulses, the width count SHALL never wrap.

Reset
REQ-028 On grst, outputs SHALL be out_valid=0, out_value=0, out_err=0, overrun=0 and gamma_start=1, with g=0, FSM=IDLE and previous sample=0.
REQ-029 A grst assertion mid-gamma SHALL discard the partial capture and any held result.
REQ-030 After grst deasserts, the first gamma cycle SHALL start at g=0 in the first cycle.

Structure
REQ-031 A shared temporal package SHALL hold the FSM state enum and a function computing VW from GAMMA_CYCLE_WIDTH.
REQ-032 The gamma counter SHALL be a sub-module, gamma_counter (params GAMMA_CYCLE_WIDTH; outputs g, gamma_start, gamma_end), reusable by encoders.
REQ-033 The remaining logic (edge detection, FSM and output register) SHALL stay in temporal_decoder.

Verification (GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8, out_ready=1 unless stated)
REQ-034 Spike high at g=3..10 -> at the next g=0: out_valid=1, out_value=3, out_err=0.
REQ-035 spike_in=0 for a whole gamma -> out_value=16, out_err=0.
REQ-036 Spike high at g=2..4, then g=6..13 -> out_value=2, out_err=1; the second pulse is ignored.
REQ-037 Spike high at g=12 through the next gamma's g=3 -> first result value=12, err=1; second result value=0, err=1.
REQ-038 out_ready=0 across two gamma ends -> second result overwrites the first and overrun pulses once; setting out_ready=1 in the load cycle -> no overrun.
REQ-039 grst asserted at g=7 during a pulse -> all outputs go to reset values; after release the next result reflects only post-reset stimulus.
